// File: rtl/muldiv_seq_if.sv
// Handshake and HI/LO bus between stage_ex and the multiply sequencer.
// master drives requests; slave is the sequencer.
interface muldiv_seq_if;
    logic        start;
    logic [6:0]  opt;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        illegal_opt;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, opt, opr1, opr2, flush, hi_we, lo_we, wdata,
        input  busy, done, illegal_opt, hi, lo
    );

    modport slave (
        input  start, opt, opr1, opr2, flush, hi_we, lo_we, wdata,
        output busy, done, illegal_opt, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add MULT/MULTU sequencer owning HI/LO.
// Retires STEP multiplier bits per RUN cycle.
module muldiv_seq #(
    parameter int STEP = 1
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int          K         = 32 / STEP;
    localparam logic [4:0]  LAST      = 5'(K - 1);
    localparam logic [6:0]  OPT_MULT  = 7'h18;
    localparam logic [6:0]  OPT_MULTU = 7'h19;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        neg_q, neg_d;
    logic        done_q, done_d;
    logic        ill_q, ill_d;

    logic        is_signed, legal, accept, last;
    logic [31:0] mag1, mag2;
    logic [63:0] sum, prod;

    assign is_signed = (bus.opt == OPT_MULT);
    assign legal     = is_signed || (bus.opt == OPT_MULTU);
    assign accept    = (state_q == IDLE) && bus.start
                       && !bus.flush && legal;
    assign last      = (state_q == RUN) && (cnt_q == LAST);

    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    assign mag1 = (is_signed && bus.opr1[31]) ? 32'(-bus.opr1) : bus.opr1;
    assign mag2 = (is_signed && bus.opr2[31]) ? 32'(-bus.opr2) : bus.opr2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (bus.flush || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum = acc_q;
        for (int j = 0; j < STEP; j++) begin
            if (mplier_q[j]) sum = sum + (mcand_q << j);
        end
        prod = neg_q ? 64'(-sum) : sum;
    end

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                ill_d = bus.start && !bus.flush && !legal;
                if (accept) begin
                    mcand_d  = {32'b0, mag1};
                    mplier_d = mag2;
                    neg_d    = is_signed && (bus.opr1[31] ^ bus.opr2[31]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (!bus.flush) begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << STEP;
                    mplier_d = mplier_q >> STEP;
                    cnt_d    = cnt_q + 5'd1;
                    if (last) begin
                        hi_d   = prod[63:32];
                        lo_d   = prod[31:0];
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            ill_q    <= ill_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.illegal_opt = ill_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench: STEP=1 and STEP=4 sequencers share one stimulus stream.
// Expected products come from plain 64-bit arithmetic.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    muldiv_seq_if ifa ();
    muldiv_seq_if ifb ();

    assign ifb.start = ifa.start;
    assign ifb.opt   = ifa.opt;
    assign ifb.opr1  = ifa.opr1;
    assign ifb.opr2  = ifa.opr2;
    assign ifb.flush = ifa.flush;
    assign ifb.hi_we = ifa.hi_we;
    assign ifb.lo_we = ifa.lo_we;
    assign ifb.wdata = ifa.wdata;

    muldiv_seq #(.STEP(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    muldiv_seq #(.STEP(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] exp_a, exp_b;
    logic [63:0] ea, eb;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [6:0] op,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx, sy;
        if (op == 7'h18) begin
            sx = $signed({{32{x[31]}}, x});
            sy = $signed({{32{y[31]}}, y});
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitors: every done pulse must match the oldest pending product
    always @(negedge clk) begin
        if (ifa.done === 1'b1) begin
            check("a_done_vs_busy", 64'(ifa.busy), 64'd0);
            check("a_done_vs_ill", 64'(ifa.illegal_opt), 64'd0);
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_spurious_done: got done=1, expected none");
            end else begin
                ea = qa.pop_front();
                check("a_product", {ifa.hi, ifa.lo}, ea);
            end
        end
        if (ifb.done === 1'b1) begin
            check("b_done_vs_busy", 64'(ifb.busy), 64'd0);
            check("b_done_vs_ill", 64'(ifb.illegal_opt), 64'd0);
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_spurious_done: got done=1, expected none");
            end else begin
                eb = qb.pop_front();
                check("b_product", {ifb.hi, ifb.lo}, eb);
            end
        end
    end

    task automatic run_op(input logic [6:0] op, input logic [31:0] x,
                          input logic [31:0] y, input bit mtlo);
        int ca, cb;
        logic [63:0] e;
        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.opt   = op;
        ifa.opr1  = x;
        ifa.opr2  = y;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        e = ref_mul(op, x, y);
        qa.push_back(e);
        qb.push_back(e);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ca += int'(ifa.busy);
            cb += int'(ifb.busy);
            if (mtlo) begin
                ifa.wdata = 32'hDEAD_BEEF;
                ifa.lo_we = (i >= 1 && i <= 3);
            end
        end
        ifa.lo_we = 1'b0;
        check("a_busy_cycles", 64'(ca), 64'd32);
        check("b_busy_cycles", 64'(cb), 64'd8);
        exp_a = e;
        exp_b = e;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.start = 1'b0;
        ifa.opt   = '0;
        ifa.opr1  = '0;
        ifa.opr2  = '0;
        ifa.flush = 1'b0;
        ifa.hi_we = 1'b0;
        ifa.lo_we = 1'b0;
        ifa.wdata = '0;
        exp_a = '0;
        exp_b = '0;

        #3;
        check("rst_a_busy", 64'(ifa.busy), 64'd0);
        check("rst_a_done", 64'(ifa.done), 64'd0);
        check("rst_a_ill", 64'(ifa.illegal_opt), 64'd0);
        check("rst_a_hilo", {ifa.hi, ifa.lo}, 64'd0);
        check("rst_b_hilo", {ifb.hi, ifb.lo}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(7'h19, 32'd7, 32'd6, 1'b0);
        check("multu_7x6", {ifa.hi, ifa.lo}, 64'h0000_0000_0000_002A);
        run_op(7'h18, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(7'h18, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mult_min_sq", {ifb.hi, ifb.lo}, 64'h4000_0000_0000_0000);
        run_op(7'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_b", {ifb.hi, ifb.lo}, 64'hFFFF_FFFE_0000_0001);

        // Flush at RUN cycle 10: STEP=1 aborts, STEP=4 already finished
        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.opt   = 7'h19;
        ifa.opr1  = 32'd3;
        ifa.opr2  = 32'd5;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        qb.push_back(64'd15);
        exp_b = 64'd15;
        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.opr1  = 32'd100;
        ifa.opr2  = 32'd100;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("a_busy_pre_flush", 64'(ifa.busy), 64'd1);
        ifa.flush = 1'b1;
        @(posedge clk); #1;
        ifa.flush = 1'b0;
        check("a_busy_post_flush", 64'(ifa.busy), 64'd0);
        check("b_busy_post_flush", 64'(ifb.busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("a_flush_hold", {ifa.hi, ifa.lo}, exp_a);
        check("b_flush_result", {ifb.hi, ifb.lo}, exp_b);

        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.opt   = 7'h21;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        check("a_illegal_pulse", 64'(ifa.illegal_opt), 64'd1);
        check("b_illegal_pulse", 64'(ifb.illegal_opt), 64'd1);
        check("a_illegal_busy", 64'(ifa.busy), 64'd0);
        @(posedge clk); #1;
        check("a_illegal_clear", 64'(ifa.illegal_opt), 64'd0);
        check("a_illegal_hilo", {ifa.hi, ifa.lo}, exp_a);

        @(posedge clk); #1;
        ifa.hi_we = 1'b1;
        ifa.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        ifa.hi_we = 1'b0;
        exp_a[63:32] = 32'h1234_5678;
        exp_b[63:32] = 32'h1234_5678;
        check("a_mthi", {ifa.hi, ifa.lo}, exp_a);
        check("b_mthi", {ifb.hi, ifb.lo}, exp_b);

        run_op(7'h19, $urandom, $urandom, 1'b1);

        for (int n = 0; n < 16; n++) begin
            run_op(($urandom_range(0, 1) == 0) ? 7'h18 : 7'h19,
                   pick(), pick(), 1'b0);
        end

        // Asynchronous reset between edges while running
        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.opt   = 7'h18;
        ifa.opr1  = $urandom;
        ifa.opr2  = $urandom;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_a_busy", 64'(ifa.busy), 64'd0);
        check("arst_b_busy", 64'(ifb.busy), 64'd0);
        check("arst_a_done", 64'(ifa.done), 64'd0);
        check("arst_a_hilo", {ifa.hi, ifa.lo}, 64'd0);
        check("arst_b_hilo", {ifb.hi, ifb.lo}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_a_idle", 64'(ifa.busy), 64'd0);
        check("arst_a_hilo_after", {ifa.hi, ifa.lo}, 64'd0);

        run_op(7'h18, 32'hFFFF_FFF9, 32'd6, 1'b0);
        check("mult_neg_a", {ifa.hi, ifa.lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        repeat (4) @(posedge clk);
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
